// File: rtl/llc_reply_proxy.sv
// llc_reply_proxy: LLC-side responder on the local port of the LLC router.
// Queues ejected request flits in a small FIFO, waits LATENCY cycles after
// each dequeue, then returns BURST reply beats addressed to the requester.
// Optional feature macro: LLC_PROXY_STATS_EN adds req_cnt/rep_cnt outputs.
//
// Handshake semantics (both sides): a flit moves on a rising clk edge where
// valid and ready are both high. Once out_so is raised, out_so and out_do
// hold their values until out_ro is seen high. in_ri depends only on the FIFO
// fill level and reset; a full FIFO never accepts, even if a pop happens on
// the same edge.
module llc_reply_proxy #(
  parameter int         DATA_W     = 64,
  parameter logic [7:0] MY_X       = 8'd0,
  parameter logic [7:0] MY_Y       = 8'd0,
  parameter int         BURST      = 2,
  parameter int         LATENCY    = 2,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_si,
  output logic              in_ri,
  input  logic [DATA_W-1:0] in_di,
  output logic              out_so,
  input  logic              out_ro,
  output logic [DATA_W-1:0] out_do,
  output logic [1:0]        o_dbg_state
`ifdef LLC_PROXY_STATS_EN
  ,
  output logic [15:0]       req_cnt,
  output logic [15:0]       rep_cnt
`endif
);

  localparam int             PW        = $clog2(FIFO_DEPTH);
  localparam int             CW        = PW + 1;
  localparam logic [CW-1:0]  FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [7:0]     LAT8      = 8'(LATENCY);
  localparam logic [7:0]     LAST_BEAT = 8'(BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Request FIFO storage and bookkeeping
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  // Service FSM state and registered reply outputs
  state_t            r_state;
  logic [7:0]        r_beat;
  logic [7:0]        r_wait_cnt;
  logic [DATA_W-1:0] r_req;
  logic              r_out_so;
  logic [DATA_W-1:0] r_out_do;

  state_t            w_state_nxt;
  logic [7:0]        w_beat_nxt;
  logic [7:0]        w_wait_nxt;
  logic [DATA_W-1:0] w_req_nxt;
  logic              w_so_nxt;
  logic [DATA_W-1:0] w_do_nxt;

  // Reply beat k for a request: route back to the source, keep VC and the
  // bits above 63, advance the payload by k (wrapping at 32 bits).
  function automatic logic [DATA_W-1:0] build_reply(input logic [DATA_W-1:0] req,
                                                    input logic [7:0]        k);
    logic [DATA_W-1:0] rep;
    rep          = req;
    rep[63]      = req[63];
    rep[62]      = (req[47:40] < MY_X);
    rep[61]      = (req[39:32] < MY_Y);
    rep[60:56]   = 5'd0;
    rep[55:52]   = req[43:40];
    rep[51:48]   = req[35:32];
    rep[47:40]   = MY_X;
    rep[39:32]   = MY_Y;
    rep[31:0]    = req[31:0] + {24'd0, k};
    return rep;
  endfunction

  assign in_ri       = reset && (r_count != FULL_CNT);
  assign w_push      = in_si && in_ri;
  assign out_so      = r_out_so;
  assign out_do      = r_out_do;
  assign o_dbg_state = r_state;

  // FIFO storage write; contents need no reset since count gates reads
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_di;
    end
  end

  // FIFO pointers and fill count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register together with the registered reply outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_beat     <= '0;
      r_wait_cnt <= '0;
      r_req      <= '0;
      r_out_so   <= 1'b0;
      r_out_do   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat     <= w_beat_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_req      <= w_req_nxt;
      r_out_so   <= w_so_nxt;
      r_out_do   <= w_do_nxt;
    end
  end

  // Next-state logic: dequeue when idle, count down the service wait, then
  // step through the reply beats as the router accepts them
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_wait_nxt  = r_wait_cnt;
    w_req_nxt   = r_req;
    w_so_nxt    = r_out_so;
    w_do_nxt    = r_out_do;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_pop      = 1'b1;
          w_req_nxt  = r_mem[r_rd_ptr];
          w_beat_nxt = '0;
          w_wait_nxt = LAT8;
          if (LATENCY == 0) begin
            w_state_nxt = ST_BURST;
            w_so_nxt    = 1'b1;
            w_do_nxt    = build_reply(r_mem[r_rd_ptr], 8'd0);
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_wait_nxt = r_wait_cnt - 8'd1;
        if (r_wait_cnt == 8'd1) begin
          w_state_nxt = ST_BURST;
          w_beat_nxt  = '0;
          w_so_nxt    = 1'b1;
          w_do_nxt    = build_reply(r_req, 8'd0);
        end
      end
      ST_BURST: begin
        if (out_ro) begin
          if (r_beat == LAST_BEAT) begin
            w_so_nxt    = 1'b0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_beat_nxt = r_beat + 8'd1;
            w_do_nxt   = build_reply(r_req, r_beat + 8'd1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_so_nxt    = 1'b0;
      end
    endcase
  end

`ifdef LLC_PROXY_STATS_EN
  logic [15:0] r_req_cnt;
  logic [15:0] r_rep_cnt;

  assign req_cnt = r_req_cnt;
  assign rep_cnt = r_rep_cnt;

  // Saturating counters of accepted requests and accepted reply beats
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_cnt <= '0;
      r_rep_cnt <= '0;
    end else begin
      if (w_push && (r_req_cnt != 16'hFFFF)) begin
        r_req_cnt <= r_req_cnt + 16'd1;
      end
      if (r_out_so && out_ro && (r_rep_cnt != 16'hFFFF)) begin
        r_rep_cnt <= r_rep_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_llc_reply_proxy.sv
// tb_llc_reply_proxy: two proxy instances (A: LATENCY=2/BURST=2, B:
// LATENCY=0/BURST=1) checked every cycle against a timestamp-based model,
// plus literal reply pins for a few hand-decoded requests.
`timescale 1ns/1ps
module tb_llc_reply_proxy;

  localparam int         DW      = 72;
  localparam int         DEPTH   = 4;
  localparam int         LAT_A   = 2;
  localparam int         BURST_A = 2;
  localparam int         LAT_B   = 0;
  localparam int         BURST_B = 1;
  localparam logic [7:0] MX_A    = 8'd3;
  localparam logic [7:0] MY_A    = 8'd0;
  localparam logic [7:0] MX_B    = 8'd5;
  localparam logic [7:0] MY_B    = 8'd7;

  // Hand-decoded requests and replies (pins 0,1 on A; pin 2 on B)
  localparam logic [DW-1:0] PIN_REQ [3] = '{72'hA5_8030_0100_BEEF_0001,
                                            72'h3C_0030_0500_FFFF_FFFF,
                                            72'h01_8000_0902_1234_5678};
  localparam logic [DW-1:0] PIN_B0  [3] = '{72'hA5_C010_0300_BEEF_0001,
                                            72'h3C_0050_0300_FFFF_FFFF,
                                            72'h01_A092_0507_1234_5678};
  localparam logic [DW-1:0] PIN_B1  [3] = '{72'hA5_C010_0300_BEEF_0002,
                                            72'h3C_0050_0300_0000_0000,
                                            72'h0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_edge = 0;
  always @(posedge clk) n_edge <= n_edge + 1;

  logic [1:0]    si;
  logic [1:0]    ri;
  logic [1:0]    so;
  logic [1:0]    ro;
  logic [DW-1:0] di   [2];
  logic [DW-1:0] dout [2];
  logic [1:0]    dbg  [2];
`ifdef LLC_PROXY_STATS_EN
  logic [15:0]   req_cnt [2];
  logic [15:0]   rep_cnt [2];
`endif

  llc_reply_proxy #(.DATA_W(DW), .MY_X(MX_A), .MY_Y(MY_A), .BURST(BURST_A),
                    .LATENCY(LAT_A), .FIFO_DEPTH(DEPTH)) u_dut_a (
    .clk(clk), .reset(rst_n),
    .in_si(si[0]), .in_ri(ri[0]), .in_di(di[0]),
    .out_so(so[0]), .out_ro(ro[0]), .out_do(dout[0]),
    .o_dbg_state(dbg[0])
`ifdef LLC_PROXY_STATS_EN
    , .req_cnt(req_cnt[0]), .rep_cnt(rep_cnt[0])
`endif
  );

  llc_reply_proxy #(.DATA_W(DW), .MY_X(MX_B), .MY_Y(MY_B), .BURST(BURST_B),
                    .LATENCY(LAT_B), .FIFO_DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .reset(rst_n),
    .in_si(si[1]), .in_ri(ri[1]), .in_di(di[1]),
    .out_so(so[1]), .out_ro(ro[1]), .out_do(dout[1]),
    .o_dbg_state(dbg[1])
`ifdef LLC_PROXY_STATS_EN
    , .req_cnt(req_cnt[1]), .rep_cnt(rep_cnt[1])
`endif
  );

  // ---------------- reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  logic [DW-1:0] sv_req [2];
  int sv_act  [2];
  int sv_pop  [2];
  int sv_done [2];
  int free_e  [2];
  int acc_cnt [2];
  int hs_cnt  [2];
  int pin_e   [3] = '{-1, -1, -1};

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT_A : LAT_B;
  endfunction
  function automatic int burst_of(input int i);
    return (i == 0) ? BURST_A : BURST_B;
  endfunction

  // Reply beat k as the header rules define it
  function automatic logic [DW-1:0] exp_reply(input logic [DW-1:0] rq, input int k,
                                              input int i);
    logic [7:0]  mx;
    logic [7:0]  my;
    logic [31:0] pl;
    mx = (i == 0) ? MX_A : MX_B;
    my = (i == 0) ? MY_A : MY_B;
    pl = rq[31:0] + 32'(k);
    return {rq[71:64], rq[63], (rq[47:40] < mx), (rq[39:32] < my), 5'b0,
            rq[43:40], rq[35:32], mx, my, pl};
  endfunction

  function automatic int q_size(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic chk(input int i, input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d edge %0d: got %h expected %h", name, i, n_edge, act, exp);
    end
  endtask

  // Single compare process: checks outputs that reflect the last edge, then
  // advances the model across the upcoming edge.
  always @(negedge clk) begin
    int            last;
    int            e;
    int            occ;
    int            d;
    logic          exp_so;
    logic          exp_ri;
    logic [DW-1:0] head;
    last = n_edge;
    e    = last + 1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        if (i == 0) exp_q0.delete(); else exp_q1.delete();
        sv_act[i]  = 0;
        free_e[i]  = 0;
        acc_cnt[i] = 0;
        hs_cnt[i]  = 0;
        chk(i, "reset_so",    DW'(so[i]),  '0);
        chk(i, "reset_ri",    DW'(ri[i]),  '0);
        chk(i, "reset_do",    dout[i],     '0);
        chk(i, "reset_state", DW'(dbg[i]), '0);
`ifdef LLC_PROXY_STATS_EN
        chk(i, "reset_req_cnt", DW'(req_cnt[i]), '0);
        chk(i, "reset_rep_cnt", DW'(rep_cnt[i]), '0);
`endif
      end else begin
        occ    = q_size(i);
        exp_ri = (occ != DEPTH);
        exp_so = (sv_act[i] != 0) && (last >= sv_pop[i] + lat_of(i));
        chk(i, "in_ri",  DW'(ri[i]), DW'(exp_ri));
        chk(i, "out_so", DW'(so[i]), DW'(exp_so));
        if (exp_so) chk(i, "out_do", dout[i], exp_reply(sv_req[i], sv_done[i], i));
`ifdef LLC_PROXY_STATS_EN
        chk(i, "req_cnt", DW'(req_cnt[i]), DW'(acc_cnt[i]));
        chk(i, "rep_cnt", DW'(rep_cnt[i]), DW'(hs_cnt[i]));
`endif
        // literal pins for the isolated directed requests
        for (int p = 0; p < 3; p++) begin
          if (pin_e[p] >= 0 && ((p == 2) == (i == 1))) begin
            d = last - pin_e[p];
            if (p < 2) begin
              if (d == 2) chk(i, "pin_so_before_latency", DW'(so[i]), '0);
              if (d == 3) begin
                chk(i, "pin_first_beat_so", DW'(so[i]), DW'(1'b1));
                chk(i, "pin_beat0", dout[i], PIN_B0[p]);
              end
              if (d == 4) chk(i, "pin_beat1", dout[i], PIN_B1[p]);
              if (d == 5) chk(i, "pin_so_after_burst", DW'(so[i]), '0);
            end else begin
              if (d == 1) begin
                chk(i, "pin_lat0_so", DW'(so[i]), DW'(1'b1));
                chk(i, "pin_lat0_beat", dout[i], PIN_B0[p]);
              end
              if (d == 2) chk(i, "pin_lat0_so_after", DW'(so[i]), '0);
            end
          end
        end
        // advance across edge e
        if (exp_so && ro[i]) begin
          sv_done[i]++;
          hs_cnt[i]++;
          if (sv_done[i] == burst_of(i)) begin
            sv_act[i] = 0;
            free_e[i] = e + 1;
          end
        end
        if (sv_act[i] == 0 && occ > 0 && e >= free_e[i]) begin
          if (i == 0) head = exp_q0.pop_front(); else head = exp_q1.pop_front();
          sv_req[i]  = head;
          sv_act[i]  = 1;
          sv_pop[i]  = e;
          sv_done[i] = 0;
        end
        if (si[i] && exp_ri) begin
          if (i == 0) exp_q0.push_back(di[i]); else exp_q1.push_back(di[i]);
          acc_cnt[i]++;
          for (int p = 0; p < 3; p++) begin
            if (pin_e[p] < 0 && ((p == 2) == (i == 1)) && di[i] == PIN_REQ[p]) pin_e[p] = e;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [DW-1:0] rand_req();
    logic [DW-1:0] r;
    r = {8'($urandom), $urandom, $urandom};
    r[47:40] = 8'($urandom_range(0, 9));
    r[39:32] = 8'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic send_one(input int i, input logic [DW-1:0] v);
    si[i] = 1'b1;
    di[i] = v;
    tick();
    si[i] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    si    = 2'b00;
    ro    = 2'b11;
    di[0] = '0;
    di[1] = '0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // isolated requests with literal expectations
    send_one(0, PIN_REQ[0]);
    repeat (8) tick();
    send_one(0, PIN_REQ[1]);
    repeat (8) tick();
    send_one(1, PIN_REQ[2]);
    repeat (4) tick();

    // back-to-back on B: one beat every two cycles
    for (int k = 0; k < 4; k++) begin
      si[1] = 1'b1;
      di[1] = rand_req();
      tick();
    end
    si[1] = 1'b0;
    repeat (12) tick();

    // stall A while streaming: FIFO fills, head beat must hold
    ro[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      si[0] = 1'b1;
      di[0] = rand_req();
      tick();
    end
    si[0] = 1'b0;
    repeat (5) tick();
    ro[0] = 1'b1;
    repeat (40) tick();

    // reset during beat 0 with two requests still queued
    for (int k = 0; k < 3; k++) begin
      si[0] = 1'b1;
      di[0] = rand_req();
      tick();
    end
    si[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();

    // randomized traffic with random backpressure on both instances
    repeat (1500) begin
      for (int i = 0; i < 2; i++) begin
        si[i] = 1'($urandom_range(0, 1));
        di[i] = rand_req();
        ro[i] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    si = 2'b00;
    ro = 2'b11;
    repeat (30) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/llc_reply_proxy.md
# llc_reply_proxy

- LLC-side responder for the CD-mesh request/reply path.
- Accepts request flits ejected by the mesh at an LLC node and queues them in a small FIFO.
- After a fixed service latency, emits a BURST-beat reply per request, routed back to the requester's (SrcX, SrcY).
- Sits on the local port of the router that hosts the LLC; it is the other end of the requests issued from router local inputs.

## Interface
Parameters:
- DATA_W, 64, flit width; must be ≥64, bits above 63 pass through from request to reply unchanged.
- MY_X, 0, 8-bit X coordinate of this LLC node.
- MY_Y, 0, 8-bit Y coordinate of this LLC node.
- BURST, 2, reply beats per request, 1..255.
- LATENCY, 2, service wait cycles between dequeue and first beat, 0..255.
- FIFO_DEPTH, 4, request FIFO entries, power of two, ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_si  in  1  request flit valid.
- in_ri  out  1  request ready.
- in_di  in  DATA_W  request flit.
- out_so  out  1  reply flit valid.
- out_ro  in  1  reply ready from router local input.
- out_do  out  DATA_W  reply flit.

## Operation
Header fields (request and reply): [63] VC, [62] Dx, [61] Dy, [60:56] Rsv, [55:52] Hx, [51:48] Hy, [47:40] SrcX, [39:32] SrcY, [31:0] payload.

Request side:
- Transfer occurs on a rising edge with in_si & in_ri; the flit is pushed into the FIFO.
- in_ri = (count != FIFO_DEPTH) && reset deasserted.
- No bypass: a full FIFO refuses a push even when a pop occurs on the same edge.
- Push and pop on the same edge with count < FIFO_DEPTH: count unchanged.

FSM states:
- IDLE: if FIFO non-empty, pop the head into the request register and load wait_cnt = LATENCY. Go to BURST if LATENCY==0, else WAIT.
- WAIT: decrement wait_cnt; on the edge where wait_cnt==1, go to BURST with beat=0 and out_so set.
- BURST: out_so=1 and out_do=reply(beat). On out_so & out_ro: if beat==BURST-1, clear out_so and go to IDLE; else increment beat and update out_do.

Reply beat k (registered):
- VC = req VC; Rsv = 0.
- Hx = req SrcX[3:0]; Hy = req SrcY[3:0].
- SrcX = MY_X; SrcY = MY_Y.
- Dx = (req SrcX < MY_X); Dy = (req SrcY < MY_Y).
- payload = req payload + k, mod 2^32 (wraps).
- Bits [DATA_W-1:64] copied from the request.

General:
- out_do and out_so are stable while out_so & !out_ro.
- Requests are served strictly in arrival order.
- One request is in service at a time.

## Timing
- Reset values: out_so=0, out_do=0, in_ri=0 while reset is low, FIFO count=0, state IDLE, beat=0, wait_cnt=0.
- Reset asserted mid-burst aborts immediately; all queued and in-service requests are dropped.
- First reply beat latency: request accepted at edge E0 → pop at E0+1 → out_so high after edge E0+1+LATENCY. With LATENCY=0, out_so is high after E0+1.
- With out_ro held high, beats are back-to-back, one per cycle.
- After the last beat, one IDLE cycle before the next pop. Sustained throughput per request is BURST+LATENCY+1 cycles.
- out_ro low stalls the current beat indefinitely. FIFO acceptance continues until full.

## Configuration
- LLC_PROXY_STATS_EN defined: adds outputs req_cnt[15:0] and rep_cnt[15:0].
  - req_cnt increments on each accepted request; rep_cnt increments on each accepted reply beat.
  - Both saturate at 16'hFFFF and reset to 0.
- LLC_PROXY_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- MY_X=3, MY_Y=0, LATENCY=2, BURST=2, out_ro=1; send Hx=3, SrcX=1, SrcY=0, payload 32'hBEEF0001 → out_so high after edge E0+3 for 2 cycles. Beats carry Hx=1, Hy=0, SrcX=3, SrcY=0, Dx=1, Dy=0, payloads BEEF0001 then BEEF0002.
- MY=(0,0), request Src=(0,0), payload FFFFFFFF, BURST=2 → Dx=0, Dy=0; payloads FFFFFFFF then 00000000 (wrap).
- Hold out_ro=0 and stream 5 requests → in_ri drops after the 4th accept (FIFO_DEPTH=4 plus none in service, or 5 accepted if the first was popped). out_do stays stable. Releasing out_ro yields 10 beats in request order.
- LATENCY=0, BURST=1 → out_so high the cycle after the pop edge. Back-to-back requests yield one beat every 2 cycles.
- Drive reset low during beat 0 of a burst with 2 requests queued → out_so=0 and in_ri=0 immediately. After release, no reply appears and in_ri=1.
- With LLC_PROXY_STATS_EN: 3 requests with BURST=2 → req_cnt=3, rep_cnt=6.
